// File: rtl/apb_pkg.sv
// apb_pkg: shared types, response codes and helpers for the APB memory completer.
//   apb_state_t   : completer FSM states
//   APB_RESP_*    : PSLVERR encodings
//   apb_clog2()   : ceiling log2 for parameter derivation
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_ACCESS,
        APB_DONE
    } apb_state_t;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned apb_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_sp_ram.sv
// apb_sp_ram: DEPTH x DATA_WIDTH single-port word memory.
//   clk     : write clock
//   i_we    : write enable
//   i_be    : per-byte write enables
//   i_addr  : word index (read and write)
//   i_wdata : write data
//   o_rdata : asynchronous read data (0 for indices beyond DEPTH)
module apb_sp_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [IDX_W-1:0]        i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Byte-lane write; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Non-power-of-2 depths leave unused index codes; they read as zero.
    assign o_rdata = (64'(i_addr) < 64'(DEPTH)) ? r_mem[i_addr] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 completer in front of a single-port word memory.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   paddr    : byte address; psel/penable/pwrite/pwdata : APB request
//   pstrb    : byte strobes (only when APB_MEM_SLAVE_PSTRB_EN is defined)
//   prdata   : registered read data, zero outside a successful read
//   pready   : registered, high for exactly one cycle per completed transfer
//   pslverr  : registered error response (range or alignment), valid with pready
// Optional feature macro: APB_MEM_SLAVE_PSTRB_EN (byte-strobed writes).
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_MEM_SLAVE_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB    = apb_clog2(NBYTES);
    localparam int unsigned IDX_W  = (apb_clog2(DEPTH) < 1) ? 1 : apb_clog2(DEPTH);
    localparam int unsigned CNT_W  = 4;

    apb_state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0]  r_prdata, w_prdata_nxt;
    logic                   r_pready, w_pready_nxt;
    logic                   r_pslverr, w_pslverr_nxt;

    logic [ADDR_WIDTH-LSB-1:0] w_word;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_range_err;
    logic                      w_align_err;
    logic                      w_err;
    logic                      w_we;
    logic [NBYTES-1:0]         w_be;
    logic [DATA_WIDTH-1:0]     w_rdata;

    // Address decode: out-of-range words are errors, never aliased.
    assign w_word      = paddr[ADDR_WIDTH-1:LSB];
    assign w_idx       = paddr[LSB +: IDX_W];
    assign w_range_err = 64'(w_word) >= 64'(DEPTH);

    generate
        if (LSB == 0) begin : g_no_align
            assign w_align_err = 1'b0;
        end else begin : g_align
            assign w_align_err = |paddr[LSB-1:0];
        end
    endgenerate

    assign w_err = w_range_err | w_align_err;

`ifdef APB_MEM_SLAVE_PSTRB_EN
    assign w_be = pstrb;
`else
    assign w_be = '1;
`endif

    // Write commits on the edge that ends the pready cycle; reset suppresses it.
    assign w_we = (r_state == APB_DONE) && psel && pwrite && !w_err && !rst;

    apb_sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_idx),
        .i_wdata (pwdata),
        .o_rdata (w_rdata)
    );

    // State and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= APB_IDLE;
            r_cnt     <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
        end
    end

    // Next state; response outputs default to cleared every cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_prdata_nxt  = '0;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        unique case (r_state)
            APB_IDLE: begin
                // psel with penable here is a protocol violation and is ignored.
                if (psel && !penable) begin
                    w_state_nxt = APB_ACCESS;
                    w_cnt_nxt   = CNT_W'(WAIT_STATES);
                end
            end
            APB_ACCESS: begin
                if (!psel) begin
                    w_state_nxt = APB_IDLE;
                end else if (penable) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt   = APB_DONE;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_err ? APB_RESP_ERR : APB_RESP_OKAY;
                        if (!pwrite && !w_err) begin
                            w_prdata_nxt = w_rdata;
                        end
                    end
                end
            end
            APB_DONE: begin
                w_state_nxt = APB_IDLE;
            end
            default: begin
                w_state_nxt = APB_IDLE;
            end
        endcase
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: randomized self-checking bench for apb_mem_slave
// (DATA_WIDTH=32, DEPTH=200, WAIT_STATES=2) against an array-based memory model.
module tb_apb_mem_slave;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 200;
    localparam int unsigned WS    = 2;

    logic          clk;
    logic          rst;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    logic [31:0] model [DEPTH];
    int n_pass;
    int n_total;

    apb_mem_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
`ifdef APB_MEM_SLAVE_PSTRB_EN
        .pstrb   (pstrb),
`endif
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full APB transfer, checked against the model; updates the model on good writes.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
        bit          exp_err;
        int          idx;
        int          lat;
        logic [3:0]  eff_strb;
        logic [31:0] exp_rd;
        idx     = int'(addr >> 2);
        exp_err = ((addr >> 2) >= 32'(DEPTH)) || (addr[1:0] != 2'b00);
`ifdef APB_MEM_SLAVE_PSTRB_EN
        eff_strb = strb;
`else
        eff_strb = 4'hF;
`endif
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!pready && lat < 40);
        check("latency", 64'(lat), 64'(WS + 1));
        check("pslverr", 64'(pslverr), 64'(exp_err));
        exp_rd = (wr || exp_err) ? 32'h0 : model[idx];
        check(wr ? "wr_prdata" : "rd_prdata", 64'(prdata), 64'(exp_rd));
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        check("pready_one_cycle", 64'(pready), 64'd0);
        if (wr && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic rd(input logic [31:0] addr);
        xfer(1'b0, addr, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        xfer(1'b1, addr, data, 4'hF);
    endtask

    // Write that is abandoned by dropping psel after one ACCESS cycle.
    task automatic abort_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check("abort_acc_pready", 64'(pready), 64'd0);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle_pready", 64'(pready), 64'd0);
        end
    endtask

    // Write interrupted by a one-cycle reset during ACCESS.
    task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        check("rst_mid_pready", 64'(pready), 64'd0);
        check("rst_mid_prdata", 64'(prdata), 64'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        if (k == 0) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            a[1:0] = 2'($urandom_range(1, 3));
        end else if (k == 1) begin
            a = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(DEPTH, DEPTH + 40)) << 2)
                                            : 32'hFFFF_FFFC;
        end else begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        end
        return a;
    endfunction

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_pready",  64'(pready),  64'd0);
        check("reset_pslverr", 64'(pslverr), 64'd0);
        check("reset_prdata",  64'(prdata),  64'd0);

        // Give every word a known value.
        for (int i = 0; i < int'(DEPTH); i++) begin
            wr(32'(i) << 2, $urandom);
        end

        // Basic write then read.
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10);
        check("rd_deadbeef", 64'(model[4]), 64'hDEAD_BEEF);

        // Range and alignment errors, plus boundary words.
        rd(32'h320);
        wr(32'h322, 32'h0BAD_0BAD);
        rd(32'h0);
        wr(32'h31C, 32'h1357_9BDF);
        rd(32'h31C);
        rd(32'h01);

        // Aborted write leaves memory unchanged.
        wr(32'h8, 32'h0102_0304);
        abort_write(32'h8, 32'hA5A5_A5A5);
        rd(32'h8);

        // Reset during ACCESS suppresses the write.
        reset_mid_write(32'h4, 32'h55);
        rd(32'h4);

        // psel+penable in IDLE without SETUP is ignored.
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFF_0000;
        repeat (3) begin
            @(negedge clk);
            check("violation_pready", 64'(pready), 64'd0);
        end
        psel = 1'b0; penable = 1'b0;
        rd(32'hC);

`ifdef APB_MEM_SLAVE_PSTRB_EN
        xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b1, 32'h20, 32'h1122_3344, 4'b0101);
        rd(32'h20);
        check("strb_merge", 64'(model[8]), 64'hFF22_FF44);
        xfer(1'b1, 32'h20, 32'h0000_0000, 4'b0000);
        rd(32'h20);
`endif

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                xfer(1'b1, rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            end else begin
                rd(rand_addr());
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
